// File: rtl/ifft_4_stream.sv
// ifft_4_stream
// Streaming 4-point inverse DFT for the OFDM transmit path. One symbol of
// four frequency-domain bins (X0..X3, in arrival order) is collected, run
// through a two-stage radix-4 butterfly and emitted as four time-domain
// samples (n = 0..3). No 1/N scaling is applied here.
//
// Handshake: a transfer happens on any rising edge where valid & ready are
// both high. s_ready and m_valid are decoded from the FSM state alone and
// never look at s_valid or m_ready; data must be held while valid is high
// and ready is low.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   s_valid  input bin valid
//   s_ready  block accepts an input bin (COLLECT state only)
//   s_re     input bin real part, signed IW bits
//   s_im     input bin imaginary part, signed IW bits
//   m_valid  output sample valid (EMIT state only)
//   m_ready  downstream accepts the output sample
//   m_re     output sample real part, signed OW bits
//   m_im     output sample imaginary part, signed OW bits
//   m_last   marks sample n = 3 of each symbol
module ifft_4_stream #(
  parameter int IW = 8,
  parameter int OW = IW + 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [IW-1:0] s_re,
  input  logic [IW-1:0] s_im,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [OW-1:0] m_re,
  output logic [OW-1:0] m_im,
  output logic          m_last
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    STAGE1  = 2'd1,
    STAGE2  = 2'd2,
    EMIT    = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [1:0] in_cnt;
  logic [1:0] out_cnt;
  logic       in_xfer;
  logic       out_xfer;

  // Captured bins: slot 0 = A = X0 ... slot 3 = D = X3.
  logic signed [IW-1:0] slot_re [4];
  logic signed [IW-1:0] slot_im [4];

  // First butterfly stage, one bit of growth.
  logic signed [IW:0] s_ac_re, s_ac_im, s_bd_re, s_bd_im;
  logic signed [IW:0] d_ac_re, d_ac_im, d_bd_re, d_bd_im;

  // Final results, two bits of growth: full precision, cannot overflow.
  logic signed [IW+1:0] x_re [4];
  logic signed [IW+1:0] x_im [4];

  assign s_ready  = (state == COLLECT);
  assign m_valid  = (state == EMIT);
  assign in_xfer  = s_valid & s_ready;
  assign out_xfer = m_valid & m_ready;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) state <= COLLECT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (in_xfer && in_cnt == 2'd3) state_nxt = STAGE1;
      STAGE1:  state_nxt = STAGE2;
      STAGE2:  state_nxt = EMIT;
      EMIT:    if (out_xfer && out_cnt == 2'd3) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  // ----------------------------------------------------------- counters
  // Both counters are 2 bits wide, so the 3 -> 0 wrap is the natural
  // overflow of the increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_cnt  <= 2'd0;
      out_cnt <= 2'd0;
    end else begin
      if (in_xfer) in_cnt <= in_cnt + 2'd1;
      if (state == STAGE2)  out_cnt <= 2'd0;
      else if (out_xfer)    out_cnt <= out_cnt + 2'd1;
    end
  end

  // ------------------------------------------------------------ capture
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        slot_re[i] <= '0;
        slot_im[i] <= '0;
      end
    end else if (in_xfer) begin
      slot_re[in_cnt] <= s_re;
      slot_im[in_cnt] <= s_im;
    end
  end

  // ------------------------------------------------------------ stage 1
  always_ff @(posedge clk) begin
    if (rst) begin
      s_ac_re <= '0; s_ac_im <= '0; s_bd_re <= '0; s_bd_im <= '0;
      d_ac_re <= '0; d_ac_im <= '0; d_bd_re <= '0; d_bd_im <= '0;
    end else if (state == STAGE1) begin
      s_ac_re <= (IW+1)'(slot_re[0]) + (IW+1)'(slot_re[2]);
      s_ac_im <= (IW+1)'(slot_im[0]) + (IW+1)'(slot_im[2]);
      s_bd_re <= (IW+1)'(slot_re[1]) + (IW+1)'(slot_re[3]);
      s_bd_im <= (IW+1)'(slot_im[1]) + (IW+1)'(slot_im[3]);
      d_ac_re <= (IW+1)'(slot_re[0]) - (IW+1)'(slot_re[2]);
      d_ac_im <= (IW+1)'(slot_im[0]) - (IW+1)'(slot_im[2]);
      d_bd_re <= (IW+1)'(slot_re[1]) - (IW+1)'(slot_re[3]);
      d_bd_im <= (IW+1)'(slot_im[1]) - (IW+1)'(slot_im[3]);
    end
  end

  // ------------------------------------------------------------ stage 2
  // Inverse transform twiddles are +j for n = 1 and -j for n = 3, so the
  // odd outputs combine dAC with dBD rotated by +/-90 degrees.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        x_re[i] <= '0;
        x_im[i] <= '0;
      end
    end else if (state == STAGE2) begin
      x_re[0] <= (IW+2)'(s_ac_re) + (IW+2)'(s_bd_re);
      x_im[0] <= (IW+2)'(s_ac_im) + (IW+2)'(s_bd_im);
      x_re[1] <= (IW+2)'(d_ac_re) - (IW+2)'(d_bd_im);
      x_im[1] <= (IW+2)'(d_ac_im) + (IW+2)'(d_bd_re);
      x_re[2] <= (IW+2)'(s_ac_re) - (IW+2)'(s_bd_re);
      x_im[2] <= (IW+2)'(s_ac_im) - (IW+2)'(s_bd_im);
      x_re[3] <= (IW+2)'(d_ac_re) + (IW+2)'(d_bd_im);
      x_im[3] <= (IW+2)'(d_ac_im) - (IW+2)'(d_bd_re);
    end
  end

  // ------------------------------------------------------------- output
  // Results are signed, so the size cast sign-extends to OW.
  assign m_re   = OW'(x_re[out_cnt]);
  assign m_im   = OW'(x_im[out_cnt]);
  assign m_last = m_valid && (out_cnt == 2'd3);

endmodule

// File: tb/tb_ifft_4_stream.sv
// tb_ifft_4_stream
// Self-checking bench for ifft_4_stream. Expected samples come from a direct
// IDFT model, x[n] = sum_k X[k] * j^(n*k), queued in exp_q per symbol.
module tb_ifft_4_stream;

  localparam int IW = 8;
  localparam int OW = IW + 2;

  // ------------------------------------------------- clock / reset block
  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [IW-1:0] s_re;
  logic [IW-1:0] s_im;
  logic          m_valid;
  logic          m_ready;
  logic [OW-1:0] m_re;
  logic [OW-1:0] m_im;
  logic          m_last;

  always #5 clk = ~clk;

  ifft_4_stream #(.IW(IW), .OW(OW)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_re    (s_re),
    .s_im    (s_im),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_re    (m_re),
    .m_im    (m_im),
    .m_last  (m_last)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ----------------------------------------------------------- scoreboard
  int checks = 0;
  int errors = 0;
  logic [2*OW-1:0] exp_q[$];

  int b_re[4];
  int b_im[4];
  int gap[4];

  task automatic set_bins(input int r0, input int i0, input int r1, input int i1,
                          input int r2, input int i2, input int r3, input int i3);
    b_re[0] = r0; b_im[0] = i0; b_re[1] = r1; b_im[1] = i1;
    b_re[2] = r2; b_im[2] = i2; b_re[3] = r3; b_im[3] = i3;
  endtask

  task automatic rand_bins();
    for (int k = 0; k < 4; k++) begin
      b_re[k] = int'($urandom_range(0, 255)) - 128;
      b_im[k] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  // Reference: plain complex IDFT with twiddle j^(n*k), no scaling.
  task automatic model_push();
    for (int n = 0; n < 4; n++) begin
      int acc_re;
      int acc_im;
      logic [OW-1:0] r;
      logic [OW-1:0] i;
      acc_re = 0;
      acc_im = 0;
      for (int k = 0; k < 4; k++) begin
        case ((n * k) % 4)
          0: begin acc_re += b_re[k]; acc_im += b_im[k]; end
          1: begin acc_re -= b_im[k]; acc_im += b_re[k]; end
          2: begin acc_re -= b_re[k]; acc_im -= b_im[k]; end
          default: begin acc_re += b_im[k]; acc_im -= b_re[k]; end
        endcase
      end
      r = acc_re[OW-1:0];
      i = acc_im[OW-1:0];
      exp_q.push_back({r, i});
    end
  endtask

  // ------------------------------------------------------- driver tasks
  task automatic send_sample(input int re, input int im, input int g);
    int t;
    s_valid = 1'b0;
    for (int c = 0; c < g; c++) begin
      checks++;
      if (s_ready !== 1'b1) begin
        errors++;
        $display("FAIL gap_s_ready: got %b expected 1", s_ready);
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b1;
    s_re = re[IW-1:0];
    s_im = im[IW-1:0];
    t = 0;
    while (s_ready !== 1'b1 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t == 50) begin
      checks++;
      errors++;
      $display("FAIL s_ready_timeout: s_ready stayed %b, expected 1", s_ready);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_re = IW'($urandom);
    s_im = IW'($urandom);
  endtask

  // Sends one symbol from b_re/b_im with gap[] idle cycles before each bin,
  // then checks the two compute cycles and the m_valid rise.
  task automatic send_symbol();
    model_push();
    for (int k = 0; k < 4; k++) send_sample(b_re[k], b_im[k], gap[k]);
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL lat_e0: m_valid=%b s_ready=%b expected 0 0", m_valid, s_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL lat_e1: m_valid=%b s_ready=%b expected 0 0", m_valid, s_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (m_valid !== 1'b1 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL lat_e2: m_valid=%b s_ready=%b expected 1 0", m_valid, s_ready);
    end
  endtask

  // Drains four samples with random stalls; bp holds m_ready low for three
  // cycles while sample n = 1 is presented.
  task automatic recv_symbol(input bit bp);
    logic [2*OW-1:0] e;
    logic [OW-1:0]   e_re;
    logic [OW-1:0]   e_im;
    int              t;
    for (int n = 0; n < 4; n++) begin
      m_ready = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      t = 0;
      while (m_valid !== 1'b1 && t < 50) begin
        @(posedge clk); #1;
        t++;
      end
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: sample %0d has no expected value", n);
        e = '0;
      end else begin
        e = exp_q.pop_front();
      end
      e_re = e[2*OW-1:OW];
      e_im = e[OW-1:0];
      checks++;
      if (m_valid !== 1'b1 || m_re !== e_re || m_im !== e_im ||
          m_last !== (n == 3) || s_ready !== 1'b0) begin
        errors++;
        $display("FAIL out_n%0d: got v=%b re=%0d im=%0d last=%b sr=%b expected v=1 re=%0d im=%0d last=%b sr=0",
                 n, m_valid, $signed(m_re), $signed(m_im), m_last, s_ready,
                 $signed(e_re), $signed(e_im), (n == 3));
      end
      if (bp && n == 1) begin
        for (int c = 0; c < 3; c++) begin
          @(posedge clk); #1;
          checks++;
          if (m_valid !== 1'b1 || m_re !== e_re || m_im !== e_im ||
              m_last !== 1'b0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold: got v=%b re=%0d im=%0d last=%b sr=%b expected v=1 re=%0d im=%0d last=0 sr=0",
                     m_valid, $signed(m_re), $signed(m_im), m_last, s_ready,
                     $signed(e_re), $signed(e_im));
          end
        end
      end
      m_ready = 1'b1;
      @(posedge clk); #1;
      m_ready = 1'b0;
    end
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL sym_end: m_valid=%b s_ready=%b expected 0 1", m_valid, s_ready);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // --------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; s_re = '0; s_im = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: s_ready=%b m_valid=%b expected 1 0", s_ready, m_valid);
    end
  endtask

  task automatic test_directed();
    gap = '{0, 0, 0, 0};
    set_bins(1, 0, 0, 0, 0, 0, 0, 0);          send_symbol(); recv_symbol(0);
    set_bins(0, 0, 1, 0, 0, 0, 0, 0);          send_symbol(); recv_symbol(0);
    set_bins(0, 0, 0, 0, 0, 0, 1, 0);          send_symbol(); recv_symbol(0);
    set_bins(-128, -128, -128, -128, -128, -128, -128, -128);
    send_symbol(); recv_symbol(0);
    set_bins(127, 127, 127, 127, 127, 127, 127, 127);
    send_symbol(); recv_symbol(0);
    set_bins(127, 0, -128, 0, 127, 0, -128, 0); send_symbol(); recv_symbol(0);
  endtask

  task automatic test_backpressure();
    gap = '{0, 0, 0, 0};
    rand_bins(); send_symbol(); recv_symbol(1);
  endtask

  task automatic test_input_gaps();
    // s_valid pattern 1,0,1,0,0,1,1
    gap = '{0, 1, 2, 0};
    rand_bins(); send_symbol(); recv_symbol(0);
  endtask

  task automatic test_reset_emit();
    gap = '{0, 0, 0, 0};
    rand_bins(); send_symbol();
    m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    m_ready = 1'b0;
    pulse_reset();
    exp_q.delete();
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_emit: m_valid=%b s_ready=%b expected 0 1", m_valid, s_ready);
    end
    m_ready = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      checks++;
      if (m_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_emit_quiet: m_valid=%b expected 0", m_valid);
      end
    end
    m_ready = 1'b0;
    rand_bins(); send_symbol(); recv_symbol(0);
  endtask

  task automatic test_reset_partial();
    gap = '{0, 0, 0, 0};
    send_sample(int'($urandom_range(0, 255)) - 128, 77, 0);
    send_sample(-5, int'($urandom_range(0, 255)) - 128, 0);
    pulse_reset();
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_partial: m_valid=%b s_ready=%b expected 0 1", m_valid, s_ready);
    end
    rand_bins(); send_symbol(); recv_symbol(0);
  endtask

  task automatic test_random();
    for (int s = 0; s < 20; s++) begin
      for (int k = 0; k < 4; k++) gap[k] = int'($urandom_range(0, 2));
      rand_bins();
      send_symbol();
      recv_symbol(bit'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_back_to_back();
    gap = '{0, 0, 0, 0};
    for (int s = 0; s < 5; s++) begin
      rand_bins();
      send_symbol();
      recv_symbol(0);
    end
  endtask

  // ---------------------------------------------------------- run + report
  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_input_gaps();
    test_reset_emit();
    test_reset_partial();
    test_random();
    test_back_to_back();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover: %0d samples never seen, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
